dmem_arbiter: RTL

Two-port arbiter and access sequencer for the single-ported 64-word data memory. It shares the memory between requester 0 (pipeline load/store unit) and requester 1 (auxiliary/debug loader) using round-robin arbitration. Each accepted request is sequenced as a one-cycle memory strobe followed by a registered response. It sits between the requesters and the memory's Address/WriteData/MemRead/MemWrite/ReadData pins, and drives the memory's 2-bit size-coded strobes: 1 = byte, 2 = halfword, 3 = word.

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the 64-word data memory.
// Define DMEM_ARB_FIXED_PRI_EN to make requester 0 win every tie.
module dmem_arbiter #(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [1:0]  req0_size,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_grant,
   output logic        req0_done,
   output logic [31:0] req0_rdata,
   output logic        req0_err,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [1:0]  req1_size,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_grant,
   output logic        req1_done,
   output logic [31:0] req1_rdata,
   output logic        req1_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_read,
   output logic [1:0]  mem_write,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        id_q, id_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        winner;
   logic        illegal;

   assign illegal = (size_q == 2'd0) || (addr_q >= 32'(DEPTH));
   assign busy    = (state_q != StIdle);

   // ptr_q holds the last winner; on a tie the other requester goes next.
   always_comb begin
      winner = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
         winner = 1'b0;
`else
         winner = ~ptr_q;
`endif
      end else if (req1_valid) begin
         winner = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      we_d       = we_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      mem_read   = 2'd0;
      mem_write  = 2'd0;
      req0_grant = 1'b0;
      req1_grant = 1'b0;
      req0_done  = 1'b0;
      req1_done  = 1'b0;
      req0_rdata = 32'h0;
      req1_rdata = 32'h0;
      req0_err   = 1'b0;
      req1_err   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0_valid || req1_valid) begin
               state_d = StAccess;
               id_d    = winner;
               ptr_d   = winner;
               we_d    = winner ? req1_we    : req0_we;
               size_d  = winner ? req1_size  : req0_size;
               addr_d  = winner ? req1_addr  : req0_addr;
               wdata_d = winner ? req1_wdata : req0_wdata;
            end
         end
         StAccess: begin
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
            if (!illegal) begin
               if (we_q) mem_write = size_q;
               else      mem_read  = size_q;
            end
            rdata_d    = (!illegal && !we_q) ? mem_rdata : 32'h0;
            err_d      = illegal;
            req0_grant = ~id_q;
            req1_grant = id_q;
            state_d    = StResp;
         end
         StResp: begin
            req0_done  = ~id_q;
            req1_done  = id_q;
            req0_rdata = id_q ? 32'h0 : rdata_q;
            req1_rdata = id_q ? rdata_q : 32'h0;
            req0_err   = ~id_q & err_q;
            req1_err   = id_q & err_q;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= 1'b1;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         we_q    <= we_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule
